tcbm_port_hs: RTL and testbench
===============================

TCBM_PORT_HS -- requirements
Module: tcbm_port_hs

Interface
REQ-001 Parameter PA_WIDTH, default 8, width of port A (1..8).
REQ-002 Parameter PB_WIDTH, default 2, width of port B (1..8).
REQ-003 Parameter PC_WIDTH, default 2, width of port C (2..8); bit PC_WIDTH-1 is the DAV input in handshake mode.
REQ-004 Parameter SYNC_STAGES, default 2, synchroniser depth for all port inputs (2..4).
REQ-005 Parameter TIMEOUT, default 255, ACK_WAIT timeout in phi2 cycles (1..65535).
REQ-006 Ports, in order:
- phi2 input 1: sole clock; all state updates on its rising edge.
- reset input 1: asynchronous, active-high.
- cs input 1: chip select, active-high.
- _write input 1: low selects write, high selects read.
- rs input 3: register select.
- data_i input 8: write data.
- data_o output 8: read data.
- data_oe output 1: read drive enable.
- pa_i/pa_o/pa_oe, each PA_WIDTH: port A pin in / out / drive enable.
- pb_i/pb_o/pb_oe, each PB_WIDTH: port B pin in / out / drive enable.
- pc_i/pc_o/pc_oe, each PC_WIDTH: port C pin in / out / drive enable.
- hs_ack output 1: handshake acknowledge, active-low.
- irq output 1: interrupt, active-high.

Function
REQ-007 Register map by rs:
- 0 PRA; 1 PRB; 2 PRC.
- 3 DDRA; 4 DDRB; 5 DDRC.
- 6 HSCTRL: bit0 handshake enable, bit1 irq enable.
- 7 HSSTAT: bit0 DV, bit1 TO, bit2 OVR, bit4:3 state code.
REQ-008 A write occurs on each rising phi2 edge with cs=1 and _write=0. Only implemented bits are stored. HSSTAT writes clear bits 0..2 wherever data_i is 1.
REQ-009 data_oe = cs & _write, combinational. data_o is combinational from rs. Unimplemented bits read 0.
REQ-010 PRx reads return the synchronised pin value for input bits (DDR=0) and the PRx register value for output bits (DDR=1).
REQ-011 Pin outputs: px_o = PRx and px_oe = DDRx, per bit.
REQ-012 Every px_i bit passes through a SYNC_STAGES flip-flop synchroniser. DAV falling-edge detection uses the last two synchronised samples.
REQ-013 Handshake FSM states and codes: IDLE=0, CAPTURE=1, ACK_WAIT=2, RELEASE=3. The FSM runs only while HSCTRL bit0 = 1. Clearing bit0 forces IDLE on the next edge.
REQ-014 IDLE -> CAPTURE on a synchronised DAV falling edge.
REQ-015 CAPTURE, one cycle:
- latch synchronised pa_i into LATA;
- if DV=1, set OVR;
- set DV;
- go to ACK_WAIT.
REQ-016 ACK_WAIT:
- hs_ack = 0;
- timeout counter counts up from 0;
- synchronised DAV high -> RELEASE;
- counter reaching TIMEOUT -> set TO and go to IDLE.
REQ-017 RELEASE, one cycle: hs_ack = 1, then IDLE. hs_ack is registered and is 0 only in ACK_WAIT.
REQ-018 While HSCTRL bit0 = 1, a PRA read returns LATA in place of the live port. DV clears on the first cycle of that read, i.e. the rising edge where cs&_write&rs==0 is true and was false on the previous cycle.
REQ-019 If a DV clear and a DV set (CAPTURE) fall on the same edge, the set wins and OVR is not set.
REQ-020 irq = HSCTRL bit1 & (DV | TO | OVR), registered, with one-cycle latency after the flag changes.
REQ-021 The timeout counter is 16 bits wide, saturates, and resets to 0 on every ACK_WAIT entry.

Reset
REQ-022 On reset=1, asynchronously:
- all PRx, DDRx, HSCTRL, HSSTAT, LATA, counter and synchronisers go to 0;
- the synchroniser for the DAV bit goes to 1;
- the FSM goes to IDLE;
- hs_ack=1, irq=0, all px_oe=0.
REQ-023 A reset asserted mid-handshake releases hs_ack within the same reset assertion; there is no recovery sequence.

Verification
REQ-024 Write DDRA=0xF0 then PRA=0xA5 with pa_i=0x0C → pa_oe=0xF0, pa_o=0xA5; PRA read after SYNC_STAGES cycles returns 0xAC.
REQ-025 PB_WIDTH=2: write DDRB=0xFF → read DDRB returns 0x03; read PRB with pb_i=2'b10 and DDRB=0 returns 0x02.
REQ-026 HSCTRL=0x03, pa_i=0x5A, DAV 1→0 → hs_ack=0 at SYNC_STAGES+2 edges, DV=1, irq=1 one edge later; DAV 0→1 → hs_ack=1 after RELEASE; PRA read returns 0x5A; irq=0 after the following edge.
REQ-027 Two DAV strobes with no PRA read between them → OVR=1, LATA holds the second value; HSSTAT write 0x07 clears all flags.
REQ-028 TIMEOUT=4, DAV held low → TO=1 and FSM in IDLE after 4 ACK_WAIT cycles, hs_ack=1.
REQ-029 reset pulsed during ACK_WAIT → hs_ack=1, HSSTAT=0, all px_oe=0 asynchronously.

Source files
------------

// File: rtl/tcbm_port_hs.sv
// rtl/tcbm_port_hs.sv - three-port parallel I/O block with DAV/ACK input handshake on port A
module tcbm_port_hs #(
    parameter int PA_WIDTH    = 8,
    parameter int PB_WIDTH    = 2,
    parameter int PC_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                phi2,
    input  logic                reset,
    input  logic                cs,
    input  logic                _write,
    input  logic [2:0]          rs,
    input  logic [7:0]          data_i,
    output logic [7:0]          data_o,
    output logic                data_oe,
    input  logic [PA_WIDTH-1:0] pa_i,
    output logic [PA_WIDTH-1:0] pa_o,
    output logic [PA_WIDTH-1:0] pa_oe,
    input  logic [PB_WIDTH-1:0] pb_i,
    output logic [PB_WIDTH-1:0] pb_o,
    output logic [PB_WIDTH-1:0] pb_oe,
    input  logic [PC_WIDTH-1:0] pc_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [PC_WIDTH-1:0] pc_oe,
    output logic                hs_ack,
    output logic                irq
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_ACK_WAIT = 2'd2,
        ST_RELEASE  = 2'd3
    } hs_state_t;

    localparam logic [PC_WIDTH-1:0] PC_SYNC_RST = {1'b1, {(PC_WIDTH-1){1'b0}}};
    localparam logic [15:0]         TO_LIM      = 16'(TIMEOUT);

    logic [PA_WIDTH-1:0] pra_q, pra_d, ddra_q, ddra_d, lata_q, lata_d;
    logic [PB_WIDTH-1:0] prb_q, prb_d, ddrb_q, ddrb_d;
    logic [PC_WIDTH-1:0] prc_q, prc_d, ddrc_q, ddrc_d;
    logic [1:0]          hsctrl_q, hsctrl_d;
    logic                dv_q, dv_d, to_q, to_d, ovr_q, ovr_d;
    logic [15:0]         cnt_q, cnt_d, cnt_inc;
    hs_state_t           state_q, state_d;
    logic                hs_ack_q, hs_ack_d, irq_q, irq_d;
    logic                rd_pra_q, rd_pra_d, dav_prev_q, dav_prev_d;

    logic [SYNC_STAGES-1:0][PA_WIDTH-1:0] pa_sync_q, pa_sync_d;
    logic [SYNC_STAGES-1:0][PB_WIDTH-1:0] pb_sync_q, pb_sync_d;
    logic [SYNC_STAGES-1:0][PC_WIDTH-1:0] pc_sync_q, pc_sync_d;

    logic [PA_WIDTH-1:0] pa_s;
    logic [PB_WIDTH-1:0] pb_s;
    logic [PC_WIDTH-1:0] pc_s;
    logic                dav_s, dav_fall, wr_en, rd_pra, dv_clr;

    assign pa_s     = pa_sync_q[SYNC_STAGES-1];
    assign pb_s     = pb_sync_q[SYNC_STAGES-1];
    assign pc_s     = pc_sync_q[SYNC_STAGES-1];
    assign dav_s    = pc_s[PC_WIDTH-1];
    assign dav_fall = dav_prev_q & ~dav_s;
    assign wr_en    = cs & ~_write;
    assign rd_pra   = cs & _write & (rs == 3'd0);
    // DV is consumed only by the first cycle of a PRA read, not by a held read
    assign dv_clr   = rd_pra & ~rd_pra_q & hsctrl_q[0];
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            pra_q      <= '0;
            prb_q      <= '0;
            prc_q      <= '0;
            ddra_q     <= '0;
            ddrb_q     <= '0;
            ddrc_q     <= '0;
            lata_q     <= '0;
            hsctrl_q   <= '0;
            dv_q       <= 1'b0;
            to_q       <= 1'b0;
            ovr_q      <= 1'b0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            hs_ack_q   <= 1'b1;
            irq_q      <= 1'b0;
            rd_pra_q   <= 1'b0;
            dav_prev_q <= 1'b1;
            pa_sync_q  <= '0;
            pb_sync_q  <= '0;
            pc_sync_q  <= {SYNC_STAGES{PC_SYNC_RST}};
        end else begin
            pra_q      <= pra_d;
            prb_q      <= prb_d;
            prc_q      <= prc_d;
            ddra_q     <= ddra_d;
            ddrb_q     <= ddrb_d;
            ddrc_q     <= ddrc_d;
            lata_q     <= lata_d;
            hsctrl_q   <= hsctrl_d;
            dv_q       <= dv_d;
            to_q       <= to_d;
            ovr_q      <= ovr_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            hs_ack_q   <= hs_ack_d;
            irq_q      <= irq_d;
            rd_pra_q   <= rd_pra_d;
            dav_prev_q <= dav_prev_d;
            pa_sync_q  <= pa_sync_d;
            pb_sync_q  <= pb_sync_d;
            pc_sync_q  <= pc_sync_d;
        end
    end

    always_comb begin
        pra_d      = pra_q;
        prb_d      = prb_q;
        prc_d      = prc_q;
        ddra_d     = ddra_q;
        ddrb_d     = ddrb_q;
        ddrc_d     = ddrc_q;
        lata_d     = lata_q;
        hsctrl_d   = hsctrl_q;
        dv_d       = dv_q;
        to_d       = to_q;
        ovr_d      = ovr_q;
        cnt_d      = cnt_q;
        state_d    = ST_IDLE;
        rd_pra_d   = rd_pra;
        dav_prev_d = dav_s;
        pa_sync_d  = {pa_sync_q[SYNC_STAGES-2:0], pa_i};
        pb_sync_d  = {pb_sync_q[SYNC_STAGES-2:0], pb_i};
        pc_sync_d  = {pc_sync_q[SYNC_STAGES-2:0], pc_i};

        if (wr_en) begin
            case (rs)
                3'd0: pra_d    = data_i[PA_WIDTH-1:0];
                3'd1: prb_d    = data_i[PB_WIDTH-1:0];
                3'd2: prc_d    = data_i[PC_WIDTH-1:0];
                3'd3: ddra_d   = data_i[PA_WIDTH-1:0];
                3'd4: ddrb_d   = data_i[PB_WIDTH-1:0];
                3'd5: ddrc_d   = data_i[PC_WIDTH-1:0];
                3'd6: hsctrl_d = data_i[1:0];
                default: begin
                    dv_d  = dv_q  & ~data_i[0];
                    to_d  = to_q  & ~data_i[1];
                    ovr_d = ovr_q & ~data_i[2];
                end
            endcase
        end
        if (dv_clr) begin
            dv_d = 1'b0;
        end

        // Flag clears above are overridden by the sets below on a coincident edge
        if (hsctrl_q[0]) begin
            case (state_q)
                ST_IDLE: begin
                    if (dav_fall) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    lata_d = pa_s;
                    if (dv_q && !dv_clr) ovr_d = 1'b1;
                    dv_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ACK_WAIT;
                end
                ST_ACK_WAIT: begin
                    if (dav_s) begin
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= TO_LIM) begin
                            to_d    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_ACK_WAIT;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        hs_ack_d = (state_d != ST_ACK_WAIT);
        irq_d    = hsctrl_q[1] & (dv_q | to_q | ovr_q);
    end

    always_comb begin
        data_o = '0;
        case (rs)
            3'd0: data_o[PA_WIDTH-1:0] = hsctrl_q[0] ? lata_q : ((pra_q & ddra_q) | (pa_s & ~ddra_q));
            3'd1: data_o[PB_WIDTH-1:0] = (prb_q & ddrb_q) | (pb_s & ~ddrb_q);
            3'd2: data_o[PC_WIDTH-1:0] = (prc_q & ddrc_q) | (pc_s & ~ddrc_q);
            3'd3: data_o[PA_WIDTH-1:0] = ddra_q;
            3'd4: data_o[PB_WIDTH-1:0] = ddrb_q;
            3'd5: data_o[PC_WIDTH-1:0] = ddrc_q;
            3'd6: data_o[1:0]          = hsctrl_q;
            default: data_o[4:0]       = {state_q, ovr_q, to_q, dv_q};
        endcase
    end

    assign data_oe = cs & _write;
    assign pa_o    = pra_q;
    assign pa_oe   = ddra_q;
    assign pb_o    = prb_q;
    assign pb_oe   = ddrb_q;
    assign pc_o    = prc_q;
    assign pc_oe   = ddrc_q;
    assign hs_ack  = hs_ack_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_tcbm_port_hs.sv
// tb/tb_tcbm_port_hs.sv - directed and randomized checks of tcbm_port_hs against a behavioural model
module tb_tcbm_port_hs;
    localparam int S    = 2;
    localparam int TOUT = 4;

    logic       phi2 = 1'b0;
    logic       reset, cs, _write;
    logic [2:0] rs;
    logic [7:0] data_i, data_o;
    logic       data_oe;
    logic [7:0] pa_i, pa_o, pa_oe;
    logic [1:0] pb_i, pb_o, pb_oe, pc_i, pc_o, pc_oe;
    logic       hs_ack, irq;

    int errors  = 0;
    int checks  = 0;
    int printed = 0;

    always #5 phi2 = ~phi2;

    tcbm_port_hs #(
        .PA_WIDTH(8), .PB_WIDTH(2), .PC_WIDTH(2), .SYNC_STAGES(S), .TIMEOUT(TOUT)
    ) dut (
        .phi2(phi2), .reset(reset), .cs(cs), ._write(_write), .rs(rs),
        .data_i(data_i), .data_o(data_o), .data_oe(data_oe),
        .pa_i(pa_i), .pa_o(pa_o), .pa_oe(pa_oe),
        .pb_i(pb_i), .pb_o(pb_o), .pb_oe(pb_oe),
        .pc_i(pc_i), .pc_o(pc_o), .pc_oe(pc_oe),
        .hs_ack(hs_ack), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (printed < 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
            printed++;
        end
    endtask

    // Behavioural model: pin histories stand in for the synchronisers
    logic [7:0] m_pra, m_ddra, m_lata;
    logic [1:0] m_prb, m_ddrb, m_prc, m_ddrc;
    logic [7:0] ha [0:S];
    logic [1:0] hb [0:S];
    logic [1:0] hc [0:S];
    logic       m_en, m_irqen, m_dv, m_to, m_ovr, m_ack, m_irq, m_rdprev;
    int         m_phase, m_wait;

    task automatic model_reset();
        m_pra = 0; m_ddra = 0; m_lata = 0; m_prb = 0; m_ddrb = 0; m_prc = 0; m_ddrc = 0;
        for (int i = 0; i <= S; i++) begin
            ha[i] = 8'h00; hb[i] = 2'b00; hc[i] = 2'b10;
        end
        m_en = 0; m_irqen = 0; m_dv = 0; m_to = 0; m_ovr = 0;
        m_ack = 1; m_irq = 0; m_rdprev = 0; m_phase = 0; m_wait = 0;
    endtask

    task automatic model_step();
        logic [7:0] sa;
        logic dav, dav_before, wr, rdp, first, ndv, nto, novr, nirq;
        int nphase, nwait;
        sa = ha[S-1];
        dav = hc[S-1][1];
        dav_before = hc[S][1];
        wr = cs & ~_write;
        rdp = cs & _write & (rs == 3'd0);
        first = rdp & ~m_rdprev & m_en;
        nirq = m_irqen & (m_dv | m_to | m_ovr);
        ndv = m_dv; nto = m_to; novr = m_ovr;
        if (wr && rs == 3'd7) begin
            if (data_i[0]) ndv = 0;
            if (data_i[1]) nto = 0;
            if (data_i[2]) novr = 0;
        end
        if (first) ndv = 0;
        nphase = 0;
        nwait = m_wait;
        if (m_en) begin
            if (m_phase == 0) begin
                nphase = (dav_before && !dav) ? 1 : 0;
            end else if (m_phase == 1) begin
                m_lata = sa;
                if (m_dv && !first) novr = 1;
                ndv = 1;
                nphase = 2;
                nwait = 0;
            end else if (m_phase == 2) begin
                if (dav) nphase = 3;
                else if (m_wait + 1 >= TOUT) begin nto = 1; nphase = 0; end
                else begin nphase = 2; nwait = m_wait + 1; end
            end
        end
        if (wr) begin
            case (rs)
                3'd0: m_pra = data_i;
                3'd1: m_prb = data_i[1:0];
                3'd2: m_prc = data_i[1:0];
                3'd3: m_ddra = data_i;
                3'd4: m_ddrb = data_i[1:0];
                3'd5: m_ddrc = data_i[1:0];
                3'd6: begin m_en = data_i[0]; m_irqen = data_i[1]; end
                default: ;
            endcase
        end
        m_dv = ndv; m_to = nto; m_ovr = novr;
        m_phase = nphase; m_wait = nwait;
        m_irq = nirq;
        m_ack = (nphase != 2);
        m_rdprev = rdp;
        for (int i = S; i > 0; i--) begin
            ha[i] = ha[i-1]; hb[i] = hb[i-1]; hc[i] = hc[i-1];
        end
        ha[0] = pa_i; hb[0] = pb_i; hc[0] = pc_i;
    endtask

    function automatic logic [7:0] exp_data();
        case (rs)
            3'd0: return m_en ? m_lata : ((m_pra & m_ddra) | (ha[S-1] & ~m_ddra));
            3'd1: return {6'b0, (m_prb & m_ddrb) | (hb[S-1] & ~m_ddrb)};
            3'd2: return {6'b0, (m_prc & m_ddrc) | (hc[S-1] & ~m_ddrc)};
            3'd3: return m_ddra;
            3'd4: return {6'b0, m_ddrb};
            3'd5: return {6'b0, m_ddrc};
            3'd6: return {6'b0, m_irqen, m_en};
            default: return {3'b0, 2'(m_phase), m_ovr, m_to, m_dv};
        endcase
    endfunction

    always @(posedge phi2 or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(negedge phi2) begin
        check("data_oe", data_oe, cs & _write);
        check("data_o", data_o, exp_data());
        check("pa_o", pa_o, m_pra);
        check("pa_oe", pa_oe, m_ddra);
        check("pb_o", pb_o, m_prb);
        check("pb_oe", pb_oe, m_ddrb);
        check("pc_o", pc_o, m_prc);
        check("pc_oe", pc_oe, m_ddrc);
        check("hs_ack", hs_ack, m_ack);
        check("irq", irq, m_irq);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge phi2);
            #2;
        end
    endtask

    task automatic idle();
        cs = 0; _write = 1;
    endtask

    task automatic wr(input logic [2:0] r, input logic [7:0] d);
        cs = 1; _write = 0; rs = r; data_i = d;
        step(1);
        idle();
    endtask

    task automatic rd_check(input string name, input logic [2:0] r, input logic [7:0] exp);
        cs = 1; _write = 1; rs = r;
        #1 check(name, data_o, exp);
    endtask

    task automatic strobe();
        pc_i = 2'b00;
        step(4);
        pc_i = 2'b10;
        step(5);
    endtask

    initial begin
        reset = 1; cs = 0; _write = 1; rs = 0; data_i = 0;
        pa_i = 0; pb_i = 0; pc_i = 2'b10;
        step(3);
        reset = 0;
        #1;
        check("rst_hs_ack", hs_ack, 1);
        check("rst_irq", irq, 0);
        check("rst_pa_oe", pa_oe, 0);
        rd_check("rst_hsstat", 3'd7, 8'h00);
        step(1); idle();

        // mixed input/output bits on port A
        pa_i = 8'h0C;
        wr(3'd3, 8'hF0);
        wr(3'd0, 8'hA5);
        #1;
        check("pa_oe_F0", pa_oe, 8'hF0);
        check("pa_o_A5", pa_o, 8'hA5);
        step(S);
        rd_check("pra_mixed", 3'd0, 8'hAC);
        step(1); idle();

        // port B width masking
        wr(3'd4, 8'hFF);
        rd_check("ddrb_mask", 3'd4, 8'h03);
        step(1); idle();
        wr(3'd4, 8'h00);
        pb_i = 2'b10;
        step(S + 1);
        rd_check("prb_in", 3'd1, 8'h02);
        step(1); idle();

        // one full handshake
        pa_i = 8'h5A;
        wr(3'd6, 8'h03);
        step(S + 1);
        pc_i = 2'b00;
        step(3);
        #1 check("ack_before", hs_ack, 1);
        step(1);
        #1 check("ack_low", hs_ack, 0);
        check("irq_lag", irq, 0);
        rd_check("hsstat_dv", 3'd7, 8'h11);
        idle();
        pc_i = 2'b10;
        step(1);
        #1 check("irq_set", irq, 1);
        step(1);
        #1 check("ack_hold", hs_ack, 0);
        step(1);
        #1 check("ack_release", hs_ack, 1);
        rd_check("hsstat_rel", 3'd7, 8'h19);
        idle();
        step(1);
        rd_check("pra_lata", 3'd0, 8'h5A);
        step(1);
        #1 check("irq_still", irq, 1);
        idle();
        step(1);
        #1 check("irq_clear", irq, 0);
        rd_check("hsstat_dvclr", 3'd7, 8'h00);
        step(1); idle();

        // overrun: two strobes without reading PRA
        pa_i = 8'h11;
        step(S + 1);
        strobe();
        pa_i = 8'h33;
        step(S + 1);
        strobe();
        rd_check("hsstat_ovr", 3'd7, 8'h05);
        wr(3'd7, 8'h07);
        rd_check("hsstat_w1c", 3'd7, 8'h00);
        step(1); idle();
        rd_check("lata_second", 3'd0, 8'h33);
        step(1); idle();

        // timeout with DAV held low
        pc_i = 2'b00;
        step(7);
        #1 check("to_ack_low", hs_ack, 0);
        rd_check("to_waiting", 3'd7, 8'h11);
        idle();
        step(1);
        #1 check("to_ack_high", hs_ack, 1);
        rd_check("to_flag", 3'd7, 8'h03);
        idle();
        pc_i = 2'b10;
        step(S + 2);

        // reset during ACK_WAIT
        pc_i = 2'b00;
        step(4);
        #1 check("pre_rst_ack", hs_ack, 0);
        reset = 1;
        #1;
        check("arst_ack", hs_ack, 1);
        check("arst_irq", irq, 0);
        check("arst_pa_oe", pa_oe, 0);
        check("arst_pb_oe", pb_oe, 0);
        check("arst_pc_oe", pc_oe, 0);
        rd_check("arst_hsstat", 3'd7, 8'h00);
        idle();
        pc_i = 2'b10;
        step(2);
        reset = 0;
        step(S + 1);

        // randomized traffic; the negedge process compares every cycle
        for (int n = 0; n < 3000; n++) begin
            cs = ($urandom_range(0, 99) < 60);
            _write = 1'($urandom_range(0, 1));
            rs = 3'($urandom_range(0, 7));
            data_i = 8'($urandom);
            if (rs == 3'd6) data_i[0] = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) pa_i = 8'($urandom);
            if ($urandom_range(0, 7) == 0) pb_i = 2'($urandom);
            if ($urandom_range(0, 7) == 0) pc_i[0] = 1'($urandom);
            if ($urandom_range(0, 5) == 0) pc_i[1] = ~pc_i[1];
            if ($urandom_range(0, 499) == 0) begin
                reset = 1;
                step(1);
                reset = 0;
            end else begin
                step(1);
            end
        end
        idle();
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
